// File: rtl/plane_interp_seq.sv
// Plane-equation interpolator: triangle setup through one shared serial divider, plus a 2-stage span evaluator.
// Latency: setup_done 4+130*CHANNELS cycles after handshake (4 if degenerate); span results 2 cycles after request.
// Backpressure: setup_ready low while a setup is in flight; span path takes one request per cycle, never stalls.
module plane_interp_seq #(
   parameter int FRAC_BITS = 8,
   parameter int WIDTH     = 32,
   parameter int CHANNELS  = 4,
   parameter int SPAN_LOG2 = 3
) (
   input  logic                                       clock,
   input  logic                                       reset,
   input  logic                                       setup_valid,
   output logic                                       setup_ready,
   input  logic [WIDTH-1:0]                           vx1,
   input  logic [WIDTH-1:0]                           vx2,
   input  logic [WIDTH-1:0]                           vx3,
   input  logic [WIDTH-1:0]                           vy1,
   input  logic [WIDTH-1:0]                           vy2,
   input  logic [WIDTH-1:0]                           vy3,
   input  logic [CHANNELS*WIDTH-1:0]                  attr1,
   input  logic [CHANNELS*WIDTH-1:0]                  attr2,
   input  logic [CHANNELS*WIDTH-1:0]                  attr3,
   output logic                                       setup_done,
   output logic                                       degenerate,
   output logic                                       plane_valid,
   input  logic                                       span_valid_in,
   input  logic [11:0]                                span_x,
   input  logic [11:0]                                span_y,
   output logic                                       span_valid_out,
   output logic [CHANNELS*(2**SPAN_LOG2)*WIDTH-1:0]   pix_out
);

   localparam int PIX   = 2**SPAN_LOG2;
   localparam int IDX_W = $clog2(2*CHANNELS);
   localparam logic [IDX_W-1:0] LAST_DIV = IDX_W'(2*CHANNELS-1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DELTA  = 3'd1;
   localparam logic [2:0] S_CROSS  = 3'd2;
   localparam logic [2:0] S_DIV    = 3'd3;
   localparam logic [2:0] S_CONST  = 3'd4;
   localparam logic [2:0] S_COMMIT = 3'd5;

   function automatic logic signed [63:0] sext(input logic [WIDTH-1:0] v);
      return {{(64-WIDTH){v[WIDTH-1]}}, v};
   endfunction

   logic [2:0]                state;
   logic [WIDTH-1:0]          x1_r, x2_r, x3_r, y1_r, y2_r, y3_r;
   logic [CHANNELS*WIDTH-1:0] z1_r, z2_r, z3_r;
   logic signed [63:0]        dx21, dx31, dy21, dy31;
   logic signed [63:0]        dz21 [CHANNELS];
   logic signed [63:0]        dz31 [CHANNELS];
   logic signed [63:0]        cc;
   logic signed [63:0]        aa   [CHANNELS];
   logic signed [63:0]        ba   [CHANNELS];
   logic signed [63:0]        ddx  [CHANNELS];
   logic signed [63:0]        ddy  [CHANNELS];
   logic signed [63:0]        cst  [CHANNELS];
   logic signed [63:0]        sh_ddx [CHANNELS];
   logic signed [63:0]        sh_ddy [CHANNELS];
   logic signed [63:0]        sh_c   [CHANNELS];
   logic                      degen_w;

   logic [IDX_W-1:0]          div_idx;
   logic [6:0]                div_step;
   logic [63:0]               div_rem, div_quo, div_den;
   logic                      div_neg;

   logic signed [63:0]        x1s, y1s, c_nxt, div_num;
   logic signed [63:0]        z1s [CHANNELS];
   logic signed [63:0]        z2s [CHANNELS];
   logic signed [63:0]        z3s [CHANNELS];
   logic [63:0]               num_mag, den_mag, quo_nxt, quo_res, rem_nxt;
   logic [64:0]               rem_sh, rem_dif;

   assign setup_ready = (state == S_IDLE);
   assign setup_done  = (state == S_COMMIT);

   assign x1s   = sext(x1_r);
   assign y1s   = sext(y1_r);
   assign c_nxt = ((dx31 * dy21) >>> FRAC_BITS) - ((dx21 * dy31) >>> FRAC_BITS);

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         z1s[k] = sext(z1_r[k*WIDTH +: WIDTH]);
         z2s[k] = sext(z2_r[k*WIDTH +: WIDTH]);
         z3s[k] = sext(z3_r[k*WIDTH +: WIDTH]);
      end
   end

   // Division order ddx0, ddy0, ddx1, ...: even index selects Aa, odd selects Ba.
   always_comb begin
      div_num = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (div_idx == IDX_W'(2*k))   div_num = aa[k] <<< FRAC_BITS;
         if (div_idx == IDX_W'(2*k+1)) div_num = ba[k] <<< FRAC_BITS;
      end
   end

   assign num_mag = div_num[63] ? -div_num : div_num;
   assign den_mag = cc[63] ? -cc : cc;
   assign rem_sh  = {div_rem, div_quo[63]};
   assign rem_dif = rem_sh - {1'b0, div_den};
   assign quo_nxt = {div_quo[62:0], ~rem_dif[64]};
   assign rem_nxt = rem_dif[64] ? rem_sh[63:0] : rem_dif[63:0];
   assign quo_res = div_neg ? -quo_nxt : quo_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         x1_r <= '0; x2_r <= '0; x3_r <= '0;
         y1_r <= '0; y2_r <= '0; y3_r <= '0;
         z1_r <= '0; z2_r <= '0; z3_r <= '0;
         dx21 <= '0; dx31 <= '0; dy21 <= '0; dy31 <= '0;
         cc          <= '0;
         degen_w     <= 1'b0;
         degenerate  <= 1'b0;
         plane_valid <= 1'b0;
         div_idx     <= '0;
         div_step    <= '0;
         div_rem     <= '0;
         div_quo     <= '0;
         div_den     <= '0;
         div_neg     <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            dz21[k] <= '0; dz31[k] <= '0;
            aa[k]   <= '0; ba[k]   <= '0;
            ddx[k]  <= '0; ddy[k]  <= '0; cst[k] <= '0;
            sh_ddx[k] <= '0; sh_ddy[k] <= '0; sh_c[k] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (setup_valid) begin
                  x1_r <= vx1; x2_r <= vx2; x3_r <= vx3;
                  y1_r <= vy1; y2_r <= vy2; y3_r <= vy3;
                  z1_r <= attr1; z2_r <= attr2; z3_r <= attr3;
                  state <= S_DELTA;
               end
            end
            S_DELTA: begin
               dx21 <= sext(x2_r) - x1s;
               dx31 <= sext(x3_r) - x1s;
               dy21 <= sext(y2_r) - y1s;
               dy31 <= sext(y3_r) - y1s;
               for (int k = 0; k < CHANNELS; k++) begin
                  dz21[k] <= z2s[k] - z1s[k];
                  dz31[k] <= z3s[k] - z1s[k];
               end
               state <= S_CROSS;
            end
            S_CROSS: begin
               cc <= c_nxt;
               for (int k = 0; k < CHANNELS; k++) begin
                  aa[k]  <= ((dz31[k] * dy21) >>> FRAC_BITS) - ((dz21[k] * dy31) >>> FRAC_BITS);
                  ba[k]  <= ((dx31 * dz21[k]) >>> FRAC_BITS) - ((dx21 * dz31[k]) >>> FRAC_BITS);
                  // Zeroed here so a degenerate triangle falls through CONST with c = z1.
                  ddx[k] <= '0;
                  ddy[k] <= '0;
               end
               div_idx  <= '0;
               div_step <= '0;
               degen_w  <= (c_nxt == '0);
               state    <= (c_nxt == '0) ? S_CONST : S_DIV;
            end
            S_DIV: begin
               if (div_step == 7'd0) begin
                  div_rem  <= '0;
                  div_quo  <= num_mag;
                  div_den  <= den_mag;
                  div_neg  <= div_num[63] ^ cc[63];
                  div_step <= 7'd1;
               end else begin
                  div_rem <= rem_nxt;
                  div_quo <= quo_nxt;
                  if (div_step == 7'd64) begin
                     for (int k = 0; k < CHANNELS; k++) begin
                        if (div_idx == IDX_W'(2*k))   ddx[k] <= quo_res;
                        if (div_idx == IDX_W'(2*k+1)) ddy[k] <= quo_res;
                     end
                     div_step <= 7'd0;
                     if (div_idx == LAST_DIV) state <= S_CONST;
                     else div_idx <= div_idx + IDX_W'(1);
                  end else begin
                     div_step <= div_step + 7'd1;
                  end
               end
            end
            S_CONST: begin
               for (int k = 0; k < CHANNELS; k++)
                  cst[k] <= z1s[k] - ((ddx[k] * x1s) >>> FRAC_BITS) - ((ddy[k] * y1s) >>> FRAC_BITS);
               state <= S_COMMIT;
            end
            S_COMMIT: begin
               for (int k = 0; k < CHANNELS; k++) begin
                  sh_ddx[k] <= ddx[k];
                  sh_ddy[k] <= ddy[k];
                  sh_c[k]   <= cst[k];
               end
               plane_valid <= 1'b1;
               degenerate  <= degen_w;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Spans sampled on the COMMIT edge already see the new plane, so bypass the shadow then.
   logic signed [63:0] src_ddx [CHANNELS];
   logic signed [63:0] src_ddy [CHANNELS];
   logic signed [63:0] src_c   [CHANNELS];
   logic signed [63:0] s1_yc   [CHANNELS];
   logic signed [63:0] s1_bx   [CHANNELS];
   logic signed [63:0] s1_dx   [CHANNELS];
   logic               s1_vld;
   logic [11:0]        base12;
   logic signed [63:0] span_base, span_yv;
   logic               unused_span_lsb;

   assign unused_span_lsb = ^span_x[SPAN_LOG2-1:0];
   assign base12    = {span_x[11:SPAN_LOG2], {SPAN_LOG2{1'b0}}};
   assign span_base = {52'b0, base12};
   assign span_yv   = {52'b0, span_y};

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         src_ddx[k] = (state == S_COMMIT) ? ddx[k] : sh_ddx[k];
         src_ddy[k] = (state == S_COMMIT) ? ddy[k] : sh_ddy[k];
         src_c[k]   = (state == S_COMMIT) ? cst[k] : sh_c[k];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_vld         <= 1'b0;
         span_valid_out <= 1'b0;
         pix_out        <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            s1_yc[k] <= '0;
            s1_bx[k] <= '0;
            s1_dx[k] <= '0;
         end
      end else begin
         s1_vld         <= span_valid_in;
         span_valid_out <= s1_vld;
         if (span_valid_in) begin
            for (int k = 0; k < CHANNELS; k++) begin
               s1_yc[k] <= span_yv * src_ddy[k] + src_c[k];
               s1_bx[k] <= span_base * src_ddx[k];
               s1_dx[k] <= src_ddx[k];
            end
         end
         if (s1_vld) begin
            for (int k = 0; k < CHANNELS; k++)
               for (int i = 0; i < PIX; i++)
                  pix_out[(k*PIX+i)*WIDTH +: WIDTH] <= WIDTH'(s1_yc[k] + s1_bx[k] + s1_dx[k] * 64'(i));
         end
      end
   end

endmodule
